// File: rtl/extend_pkg.sv
// Shared encodings for the immediate-extension arbiter: extend modes,
// output-stage state encodings and the selected-request bundle.
package extend_pkg;

  // Extend mode encodings carried on reqN_mode
  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // Output-stage state: EMPTY has no result, FULL presents out_data
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Requester index used for out_src and the round-robin pointer
  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  // Immediate plus mode as presented to the extension core
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  mode;
  } ext_req_t;

endpackage

// File: rtl/extend_core.sv
// Combinational immediate extension: 16-bit immediate plus mode in,
// 32-bit extended value out.
module extend_core
  import extend_pkg::*;
(
  input  logic [15:0] i_data,
  input  logic [1:0]  i_mode,
  output logic [31:0] o_data
);

  // Select the extension form for the requested mode
  always_comb begin
    o_data = 32'h0000_0000;
    case (i_mode)
      MODE_SIGN:   o_data = {{16{i_data[15]}}, i_data};
      MODE_ZERO:   o_data = {16'h0000, i_data};
      MODE_UPPER:  o_data = {i_data, 16'h0000};
      MODE_BRANCH: o_data = {{14{i_data[15]}}, i_data, 2'b00};
      default:     o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/extend_arbiter.sv
// Two-requester round-robin arbiter feeding a single immediate-extension
// core, with a one-entry registered output stage (ready/valid on both sides).
module extend_arbiter
  import extend_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic [1:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic [1:0]  req1_mode,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_src,
  output logic [7:0]  served0,
  output logic [7:0]  served1
);

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [31:0] r_out_data;
  logic        r_out_src;
  logic        r_last_grant;
  logic [7:0]  r_served0;
  logic [7:0]  r_served1;

  logic        w_can_load;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_accept;
  logic        w_drain;
  ext_req_t    w_sel;
  logic [31:0] w_ext_data;

  // The stage can take a new result when empty or being drained this cycle
  assign w_can_load = (r_state == ST_EMPTY) || out_ready;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt0 = (r_last_grant == REQ_1);
      w_gnt1 = (r_last_grant == REQ_0);
    end else begin
      w_gnt0 = req0_valid;
      w_gnt1 = req1_valid;
    end
  end

  assign req0_ready = w_gnt0 && w_can_load;
  assign req1_ready = w_gnt1 && w_can_load;
  assign w_acc0     = req0_ready && req0_valid;
  assign w_acc1     = req1_ready && req1_valid;
  assign w_accept   = w_acc0 || w_acc1;
  assign w_drain    = (r_state == ST_FULL) && out_ready;

  // Route the granted requester into the single extension core
  always_comb begin
    w_sel.data = req0_data;
    w_sel.mode = req0_mode;
    if (w_gnt1) begin
      w_sel.data = req1_data;
      w_sel.mode = req1_mode;
    end
  end

  extend_core u_extend_core (
    .i_data (w_sel.data),
    .i_mode (w_sel.mode),
    .o_data (w_ext_data)
  );

  // Output-stage state transitions: accept fills, drain without accept empties
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL:  if (w_drain && !w_accept) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  // State register; reset discards any held result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result and source capture on the accepting edge; held otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data <= 32'h0000_0000;
      r_out_src  <= REQ_0;
    end else if (w_accept) begin
      r_out_data <= w_ext_data;
      r_out_src  <= w_acc1 ? REQ_1 : REQ_0;
    end
  end

  // Round-robin pointer moves only on an accepted transfer; starts at 1 so req0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= REQ_1;
    end else if (w_accept) begin
      r_last_grant <= w_acc1 ? REQ_1 : REQ_0;
    end
  end

  // Per-requester accepted-transfer counters, wrapping at 8 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_served0 <= 8'd0;
      r_served1 <= 8'd0;
    end else begin
      if (w_acc0) r_served0 <= r_served0 + 8'd1;
      if (w_acc1) r_served1 <= r_served1 + 8'd1;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign served0   = r_served0;
  assign served1   = r_served1;

endmodule

// File: tb/tb_extend_arbiter.sv
// Self-checking bench for extend_arbiter: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_extend_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_src;
  logic [7:0]  served0;
  logic [7:0]  served1;

  extend_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_mode  (req0_mode),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_mode  (req1_mode),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .served0    (served0),
    .served1    (served1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: the one-entry output slot and bookkeeping
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_src;
  logic        m_last;
  logic [7:0]  m_served0;
  logic [7:0]  m_served1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Extension rules written as plain arithmetic on integers
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
    int s;
    s = int'($signed(d));
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(d);
      2'd2:    return 32'(d) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_data    = 32'h0;
    m_src     = 1'b0;
    m_last    = 1'b1;
    m_served0 = 8'd0;
    m_served1 = 8'd0;
  endtask

  // Apply reset across two edges, release away from the edge, check reset state
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'(m_valid));
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_served0", 32'(served0), 32'h0);
    chk("rst_served1", 32'(served1), 32'h0);
  endtask

  // One cycle: drive inputs, check readies, clock, update model, check outputs
  task automatic step(input logic v0, input logic [15:0] d0, input logic [1:0] m0,
                      input logic v1, input logic [15:0] d1, input logic [1:0] m1,
                      input logic ordy);
    logic can;
    logic e_r0;
    logic e_r1;
    req0_valid = v0; req0_data = d0; req0_mode = m0;
    req1_valid = v1; req1_data = d1; req1_mode = m1;
    out_ready  = ordy;
    #1;
    can  = !m_valid || ordy;
    e_r0 = can && v0 && (!v1 || m_last == 1'b1);
    e_r1 = can && v1 && (!v0 || m_last == 1'b0);
    chk("req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(req1_ready), 32'(e_r1));
    @(posedge clk);
    if (m_valid && ordy)
      $display("xfer t=%0t src=%0d data=%h", $time, m_src, m_data);
    if (e_r0) begin
      m_valid = 1'b1; m_data = ref_ext(d0, m0); m_src = 1'b0; m_last = 1'b0;
      m_served0 = m_served0 + 8'd1;
    end else if (e_r1) begin
      m_valid = 1'b1; m_data = ref_ext(d1, m1); m_src = 1'b1; m_last = 1'b1;
      m_served1 = m_served1 + 8'd1;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_src", 32'(out_src), 32'(m_src));
    end
    chk("served0", 32'(served0), 32'(m_served0));
    chk("served1", 32'(served1), 32'(m_served1));
  endtask

  initial begin
    logic [31:0] held;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_data = 16'h0; req0_mode = 2'b00;
    req1_valid = 1'b0; req1_data = 16'h0; req1_mode = 2'b00;
    out_ready = 1'b0;
    model_reset();

    // Sign-extend from requester 0 after reset
    do_reset();
    step(1'b1, 16'h8001, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    chk("sext_data", out_data, 32'hFFFF_8001);
    chk("sext_src", 32'(out_src), 32'h0);
    chk("sext_served0", 32'(served0), 32'h1);

    // Both requesting every cycle: strict alternation starting with req0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h0004, 2'b11, 1'b1, 16'h1234, 2'b10, 1'b1);
      chk("rr_data", out_data, (i % 2 == 0) ? 32'h0000_0010 : 32'h1234_0000);
      chk("rr_src", 32'(out_src), 32'(i % 2));
    end

    // Stall for 3 cycles after one load: data held, readies low, counters frozen
    do_reset();
    step(1'b1, 16'h7FFF, 2'b11, 1'b0, 16'h0, 2'b00, 1'b1);
    held = out_data;
    chk("stall_load", held, 32'h0001_FFFC);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h1111, 2'b01, 1'b1, 16'h2222, 2'b01, 1'b0);
      chk("stall_data", out_data, 32'h0001_FFFC);
      chk("stall_served0", 32'(served0), 32'h1);
    end

    // Back-to-back req1 zero-extends with no bubble
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0, 2'b00, 1'b1, 16'hFFFF, 2'b01, 1'b1);
      chk("b2b_valid", 32'(out_valid), 32'h1);
      chk("b2b_data", out_data, 32'h0000_FFFF);
    end
    step(1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
    chk("drain_empty", 32'(out_valid), 32'h0);

    // 256 req0 accepts wrap served0 back to zero
    do_reset();
    for (int i = 0; i < 256; i++)
      step(1'b1, 16'(i), 2'(i), 1'b0, 16'h0, 2'b00, 1'b1);
    chk("wrap_served0", 32'(served0), 32'h0);

    // Asynchronous reset while full and stalled, then first tie goes to req0
    do_reset();
    step(1'b0, 16'h0, 2'b00, 1'b1, 16'hABCD, 2'b00, 1'b1);
    step(1'b1, 16'h5555, 2'b00, 1'b1, 16'h6666, 2'b00, 1'b0);
    chk("pre_arst_valid", 32'(out_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_served1", 32'(served1), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 16'h0001, 2'b01, 1'b1, 16'h0002, 2'b01, 1'b1);
    chk("arst_tie_src", 32'(out_src), 32'h0);
    chk("arst_tie_data", out_data, 32'h0000_0001);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
